// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// CU_PKG
//
// Shared types for the response statistics drain path:
//   - ResponseStatistcsInterface : live counter bundle from the statistics unit
//   - stats_drain_state          : drain controller state encoding
//   - STAT_IDX_*                 : drain order / index of each counter word
//   - stat_select()              : picks one counter by index, zero-extended
//                                  to STAT_WORD_WIDTH bits
// -----------------------------------------------------------------------------
package CU_PKG;

    localparam int STATS_COUNT_WIDTH = 32;
    localparam int STAT_WORD_WIDTH   = 64;
    localparam int STAT_INDEX_WIDTH  = 4;

    typedef struct packed {
        logic [STATS_COUNT_WIDTH-1:0] DONE_count;
        logic [STATS_COUNT_WIDTH-1:0] DONE_RESTART_count;
        logic [STATS_COUNT_WIDTH-1:0] DONE_PREFETCH_count;
        logic [STATS_COUNT_WIDTH-1:0] FLUSHED_count;
        logic [STATS_COUNT_WIDTH-1:0] PAGED_count;
        logic [STATS_COUNT_WIDTH-1:0] AERROR_count;
        logic [STATS_COUNT_WIDTH-1:0] DERROR_count;
        logic [STATS_COUNT_WIDTH-1:0] FAILED_count;
        logic [STATS_COUNT_WIDTH-1:0] FAULT_count;
        logic [STATS_COUNT_WIDTH-1:0] NRES_count;
        logic [STATS_COUNT_WIDTH-1:0] NLOCK_count;
    } ResponseStatistcsInterface;

    typedef enum logic [2:0] {
        STATS_IDLE     = 3'd0,
        STATS_COUNT    = 3'd1,
        STATS_FLUSH    = 3'd2,
        STATS_SNAPSHOT = 3'd3,
        STATS_DRAIN    = 3'd4,
        STATS_DONE     = 3'd5
    } stats_drain_state;

    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_DONE          = 4'd0;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_DONE_RESTART  = 4'd1;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_DONE_PREFETCH = 4'd2;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_FLUSHED       = 4'd3;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_PAGED         = 4'd4;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_AERROR        = 4'd5;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_DERROR        = 4'd6;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_FAILED        = 4'd7;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_FAULT         = 4'd8;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_NRES          = 4'd9;
    localparam logic [STAT_INDEX_WIDTH-1:0] STAT_IDX_NLOCK         = 4'd10;

    // Zero-extended to the widest supported word; callers resize to their
    // own data width, which truncates to the low bits when narrower.
    function automatic logic [STAT_WORD_WIDTH-1:0] stat_select(
        input ResponseStatistcsInterface stats,
        input logic [STAT_INDEX_WIDTH-1:0] index
    );
        stat_select = '0;
        case (index)
            STAT_IDX_DONE:          stat_select = STAT_WORD_WIDTH'(stats.DONE_count);
            STAT_IDX_DONE_RESTART:  stat_select = STAT_WORD_WIDTH'(stats.DONE_RESTART_count);
            STAT_IDX_DONE_PREFETCH: stat_select = STAT_WORD_WIDTH'(stats.DONE_PREFETCH_count);
            STAT_IDX_FLUSHED:       stat_select = STAT_WORD_WIDTH'(stats.FLUSHED_count);
            STAT_IDX_PAGED:         stat_select = STAT_WORD_WIDTH'(stats.PAGED_count);
            STAT_IDX_AERROR:        stat_select = STAT_WORD_WIDTH'(stats.AERROR_count);
            STAT_IDX_DERROR:        stat_select = STAT_WORD_WIDTH'(stats.DERROR_count);
            STAT_IDX_FAILED:        stat_select = STAT_WORD_WIDTH'(stats.FAILED_count);
            STAT_IDX_FAULT:         stat_select = STAT_WORD_WIDTH'(stats.FAULT_count);
            STAT_IDX_NRES:          stat_select = STAT_WORD_WIDTH'(stats.NRES_count);
            STAT_IDX_NLOCK:         stat_select = STAT_WORD_WIDTH'(stats.NLOCK_count);
            default:                stat_select = '0;
        endcase
    endfunction

endpackage

// File: rtl/response_statistics_drain_control.sv
// -----------------------------------------------------------------------------
// response_statistics_drain_control
//
// Owns the lifetime of the response statistics counter unit for one job:
// enables it on start_in, keeps it enabled FLUSH_CYCLES cycles past stop_in so
// in-flight responses land, snapshots the counters, then drains them one word
// per valid/ready handshake. Dropping the enable afterwards clears the unit,
// so every job starts from zero.
//
// Optional feature (macro RESPONSE_STATS_SKIP_ZERO_EN):
//   defined   - zero-valued counters are skipped; last marks the highest
//               nonzero index; an all-zero snapshot emits one word {0, 0, last}
//   undefined - all NUM_COUNTERS words are emitted, last on the final index
//
// Ports:
//   clock, rstn       clock; asynchronous active-low reset
//   start_in          job start pulse (taken in IDLE only)
//   stop_in           job done pulse (taken in COUNT only)
//   stats_in          live counters from the statistics unit
//   stats_enable_out  statistics unit enable (COUNT and FLUSH)
//   stat_valid_out    drained word valid
//   stat_ready_in     consumer accepts the current word
//   stat_index_out    counter index of the current word
//   stat_data_out     counter value, zero-extended / truncated to DATA_WIDTH
//   stat_last_out     current word is the final word of the drain
//   busy_out          high in every state except IDLE
//   done_out          one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module response_statistics_drain_control
    import CU_PKG::*;
#(
    parameter int FLUSH_CYCLES = 4,
    parameter int NUM_COUNTERS = 11,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                        clock,
    input  logic                        rstn,
    input  logic                        start_in,
    input  logic                        stop_in,
    input  ResponseStatistcsInterface   stats_in,
    output logic                        stats_enable_out,
    output logic                        stat_valid_out,
    input  logic                        stat_ready_in,
    output logic [STAT_INDEX_WIDTH-1:0] stat_index_out,
    output logic [DATA_WIDTH-1:0]       stat_data_out,
    output logic                        stat_last_out,
    output logic                        busy_out,
    output logic                        done_out
);

    localparam int FLUSH_WIDTH = $clog2(FLUSH_CYCLES);

    stats_drain_state          state_q, state_d;
    logic [FLUSH_WIDTH-1:0]    flush_q, flush_d;
    ResponseStatistcsInterface snapshot_q, snapshot_d;
    logic [NUM_COUNTERS-1:0]   emit_mask_q, emit_mask_d;
    logic [STAT_INDEX_WIDTH-1:0] index_q, index_d;
    logic                      last_q, last_d;

    // Which counters of the incoming snapshot will be emitted.
    logic [NUM_COUNTERS-1:0]   emit_mask_snap;

    // Index search shared by SNAPSHOT (first word) and DRAIN (next word).
    logic [NUM_COUNTERS-1:0]   search_mask;
    int                        search_from;
    logic                      search_found;
    logic                      search_more;
    logic [STAT_INDEX_WIDTH-1:0] search_idx;

    logic in_drain;

`ifdef RESPONSE_STATS_SKIP_ZERO_EN
    // Zero test is on the word as it will be emitted, so a counter whose low
    // DATA_WIDTH bits are zero is treated as zero.
    always_comb begin
        emit_mask_snap = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            emit_mask_snap[i] =
                (DATA_WIDTH'(stat_select(stats_in, STAT_INDEX_WIDTH'(i))) != '0);
        end
    end
`else
    assign emit_mask_snap = '1;
`endif

    // Lowest set mask bit at or above search_from, plus whether any further
    // set bit exists above it (that decides last for the chosen word).
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        search_mask  = emit_mask_q;
        search_from  = int'(index_q) + 1;
        search_found = 1'b0;
        search_more  = 1'b0;
        search_idx   = '0;
        if (state_q == STATS_SNAPSHOT) begin
            search_mask = emit_mask_snap;
            search_from = 0;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (i >= search_from && search_mask[i]) begin
                if (!search_found) begin
                    search_found = 1'b1;
                    search_idx   = STAT_INDEX_WIDTH'(i);
                end else begin
                    search_more = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        snapshot_d  = snapshot_q;
        emit_mask_d = emit_mask_q;
        index_d     = index_q;
        last_d      = last_q;

        case (state_q)
            STATS_IDLE: begin
                // A coincident stop_in is dropped: only start matters here.
                if (start_in) state_d = STATS_COUNT;
            end
            STATS_COUNT: begin
                if (stop_in) begin
                    state_d = STATS_FLUSH;
                    flush_d = FLUSH_WIDTH'(FLUSH_CYCLES - 1);
                end
            end
            STATS_FLUSH: begin
                if (flush_q == '0) begin
                    state_d = STATS_SNAPSHOT;
                end else begin
                    flush_d = flush_q - FLUSH_WIDTH'(1);
                end
            end
            STATS_SNAPSHOT: begin
                snapshot_d  = stats_in;
                emit_mask_d = emit_mask_snap;
                // Empty mask only happens with skip-zero on an all-zero
                // snapshot: emit a single word at index 0 marked last.
                index_d     = search_found ? search_idx : '0;
                last_d      = !search_more;
                state_d     = STATS_DRAIN;
            end
            STATS_DRAIN: begin
                if (stat_ready_in) begin
                    if (last_q) begin
                        state_d = STATS_DONE;
                    end else begin
                        index_d = search_idx;
                        last_d  = !search_more;
                    end
                end
            end
            STATS_DONE: begin
                state_d = STATS_IDLE;
            end
            default: begin
                state_d = STATS_IDLE;
            end
        endcase
    end

    // The snapshot is a handful of flops, not a RAM, and is cleared on reset
    // so nothing from an aborted job can leak into a later read.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q     <= STATS_IDLE;
            flush_q     <= '0;
            snapshot_q  <= '0;
            emit_mask_q <= '0;
            index_q     <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            snapshot_q  <= snapshot_d;
            emit_mask_q <= emit_mask_d;
            index_q     <= index_d;
            last_q      <= last_d;
        end
    end

    // Outputs decode straight from state flops, so reset forces them to zero
    // without waiting for a clock edge.
    assign in_drain         = (state_q == STATS_DRAIN);
    assign stats_enable_out = (state_q == STATS_COUNT) || (state_q == STATS_FLUSH);
    assign stat_valid_out   = in_drain;
    assign stat_index_out   = in_drain ? index_q : '0;
    assign stat_data_out    = in_drain ? DATA_WIDTH'(stat_select(snapshot_q, index_q)) : '0;
    assign stat_last_out    = in_drain && last_q;
    assign busy_out         = (state_q != STATS_IDLE);
    assign done_out         = (state_q == STATS_DONE);

endmodule

// File: doc/response_statistics_drain_control.md
# response_statistics_drain_control

Sequences the response statistics counter unit for one job: enables it at job start, keeps it enabled long enough for in-flight responses to settle, snapshots the counters, and drains them one word per handshake to the MMIO/status path. It sits between the AFU job control (start/stop pulses) and the statistics counter block (its `enabled_in` and `response_statistics_out`). It owns the counter block's lifetime, so counters are zeroed between jobs.

## Interface

Parameters:
- `FLUSH_CYCLES`, 4 — cycles `stats_enable_out` stays high after `stop_in` before the snapshot; must be ≥ 4, the counter block's enable-to-output depth.
- `NUM_COUNTERS`, 11 — number of drained counter words.
- `DATA_WIDTH`, 64 — drained word width.

Ports:
- `clock` in 1 — clock.
- `rstn` in 1 — reset, asynchronous, active-low.
- `start_in` in 1 — job start pulse.
- `stop_in` in 1 — job done pulse.
- `stats_in` in ResponseStatistcsInterface — live counters from the statistics unit.
- `stats_enable_out` out 1 — drives the statistics unit `enabled_in`.
- `stat_valid_out` out 1 — drained word valid.
- `stat_ready_in` in 1 — consumer accepts the word.
- `stat_index_out` out 4 — counter index of the current word.
- `stat_data_out` out DATA_WIDTH — counter value, zero-extended.
- `stat_last_out` out 1 — current word is the final word.
- `busy_out` out 1 — high in every state except IDLE.
- `done_out` out 1 — one-cycle pulse after the final word is accepted.

## Operation

- Counter index order:
  - 0 DONE, 1 DONE_RESTART, 2 DONE_PREFETCH, 3 FLUSHED, 4 PAGED, 5 AERROR
  - 6 DERROR, 7 FAILED, 8 FAULT, 9 NRES, 10 NLOCK
- State machine: IDLE → COUNT → FLUSH → SNAPSHOT → DRAIN → DONE → IDLE.
- IDLE:
  - All outputs 0.
  - `start_in` → COUNT.
  - `stop_in` is ignored.
- COUNT:
  - `stats_enable_out` = 1.
  - `stop_in` → FLUSH, loading the flush counter with FLUSH_CYCLES−1.
  - `start_in` is ignored.
- FLUSH:
  - `stats_enable_out` = 1.
  - Decrement the counter each cycle; at 0 → SNAPSHOT.
  - `start_in` and `stop_in` are ignored.
- SNAPSHOT (one cycle):
  - Register `stats_in` into the snapshot.
  - `stats_enable_out` = 0; the unit clears its outputs from here on.
  - Index ← first index to emit → DRAIN.
- DRAIN:
  - `stat_valid_out` = 1; `stat_data_out` comes from the snapshot at the current index.
  - On `stat_valid_out && stat_ready_in`: advance to the next emitted index. If the accepted word had `stat_last_out` = 1 → DONE.
  - While not accepted: index, data and last stay stable.
- DONE: `done_out` = 1 for one cycle → IDLE.
- Simultaneous `start_in` and `stop_in` in IDLE: start is taken and stop is dropped.
- The next job can start in the cycle after DONE.
- Snapshot field width: each field is zero-extended to DATA_WIDTH; fields wider than DATA_WIDTH are truncated to the low bits.

## Timing

- Reset value of every output is 0. All registers, including snapshot, index and state, reset to 0 / IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0, so the statistics unit is disabled and clears. There is no partial drain after reset release.
- `start_in` at cycle t → `stats_enable_out` = 1 and `busy_out` = 1 at t+1.
- `stop_in` at cycle t:
  - `stats_enable_out` stays 1 through t+FLUSH_CYCLES.
  - SNAPSHOT occurs at t+FLUSH_CYCLES+1.
  - The first valid word appears at t+FLUSH_CYCLES+2.
- With `stat_ready_in` held high, one word is accepted per cycle. `done_out` is asserted the cycle after the last acceptance.

## Configuration

- Macro `RESPONSE_STATS_SKIP_ZERO_EN`.
- Defined:
  - Counters with snapshot value 0 are not emitted.
  - `stat_last_out` marks the highest-index nonzero counter.
  - If all counters are 0, a single word is emitted: index 0, data 0, last 1.
  - The next-index search is a registered priority-encode computed in SNAPSHOT and on each accept, with no extra cycle.
- Undefined: all NUM_COUNTERS words are emitted in order 0..10; last is set on index 10.

## Structure

- CU_PKG holds:
  - State enum `stats_drain_state`.
  - Index localparams `STAT_IDX_DONE` … `STAT_IDX_NLOCK`.
  - Function `stat_select(ResponseStatistcsInterface, index)` returning the DATA_WIDTH word.
- No sub-module. The FSM, flush counter, snapshot and index logic live in one module.

## Test plan

- Basic drain:
  - Stimulus: start, hold `stats_in.DONE_count`=5 and `PAGED_count`=2, all others 0; `stop_in`; ready held high.
  - Required: 11 words; index 0 data 5, index 4 data 2, the rest 0; last only on index 10; `done_out` one cycle later.
- Backpressure:
  - Stimulus: drop `stat_ready_in` for 3 cycles on index 3.
  - Required: index, data and last stable during the stall; no skipped or duplicated index.
- Flush window:
  - Stimulus: `stats_in.NLOCK_count` changes from 1 to 2 at t+FLUSH_CYCLES after `stop_in`.
  - Required: the snapshot captures 2, and `stats_enable_out` falls at t+FLUSH_CYCLES+1.
- Ignored pulses:
  - Stimulus: `stop_in` in IDLE; `start_in` during FLUSH and DRAIN.
  - Required: no state change and no extra job.
- Reset mid-drain:
  - Stimulus: assert `rstn`=0 at index 6.
  - Required: all outputs 0 asynchronously. After release the FSM is in IDLE; a new start/stop cycle drains cleanly from index 0.
- Skip-zero (`RESPONSE_STATS_SKIP_ZERO_EN`):
  - With only `FAULT_count`=7 (index 8): exactly one word, index 8, data 7, last 1.
  - With all counters zero: one word, index 0, data 0, last 1.
